hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter AWIDTH, default 5: register address width; 2**AWIDTH architectural registers.
REQ-002 SHALL have parameter BR_WAIT, default 2: issue-blocked cycles after a branch issues (1..7).
REQ-003 SHALL have port hs_clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port hs_rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port hs_i_ce, input, 1: decode holds a valid instruction.
REQ-006 SHALL have ports hs_i_addr_rs and hs_i_addr_rt, input, AWIDTH each: source register addresses.
REQ-007 SHALL have ports hs_i_use_rs and hs_i_use_rt, input, 1 each: the instruction reads rs or rt.
REQ-008 SHALL have ports hs_i_reg_wr (1) and hs_i_addr_wr (AWIDTH), input: the instruction writes hs_i_addr_wr.
REQ-009 SHALL have port hs_i_branch, input, 1: the instruction is a branch.
REQ-010 SHALL have ports hs_i_wb_en (1) and hs_i_wb_addr (AWIDTH), input: writeback retires one write this cycle.
REQ-011 SHALL have port hs_o_issue, output, 1: the decode instruction advances this cycle.
REQ-012 SHALL have port hs_o_stall, output, 1: hs_i_ce high and hs_o_issue low.
REQ-013 SHALL have port hs_o_busy, output, 1, registered: some register has a pending write.

Function
REQ-014 SHALL keep a 2-bit pending counter per register; register 0 never counts and never causes a hazard.
REQ-015 SHALL increment the counter of hs_i_addr_wr on a cycle with hs_o_issue and hs_i_reg_wr, and decrement the counter of hs_i_wb_addr on a cycle with hs_i_wb_en.
REQ-016 SHALL leave the counter unchanged when increment and decrement hit the same register in the same cycle.
REQ-017 SHALL never decrement a zero counter: the decrement is ignored and the counter stays 0.
REQ-018 SHALL detect a RAW hazard when a used source (hs_i_use_rs/hs_i_use_rt) has a nonzero counter.
REQ-019 SHALL detect a WAW overflow when hs_i_reg_wr is high and the destination counter equals 3.
REQ-020 SHALL run an FSM with states RUN, STALL and BR_WAIT.
REQ-021 SHALL, in RUN or STALL, assert hs_o_issue combinationally when hs_i_ce is high and no hazard exists; issuing then moves to RUN.
REQ-022 SHALL move to STALL when hs_i_ce is high and a hazard exists; STALL re-evaluates every cycle with no timeout.
REQ-023 SHALL, when a branch issues, enter BR_WAIT and hold hs_o_issue low for exactly BR_WAIT cycles via a 3-bit down-counter, then return to RUN.
REQ-024 SHALL apply writebacks in all states, including BR_WAIT.
REQ-025 SHALL update hs_o_busy one cycle after the counters change.

Reset
REQ-026 SHALL, while hs_rst is low, clear all counters, set the FSM to RUN, clear the branch counter and drive hs_o_issue=0, hs_o_stall=0 and hs_o_busy=0.
REQ-027 SHALL, when reset asserts mid-stall or mid-BR_WAIT, abandon the operation; the first cycle after release behaves as RUN with an empty scoreboard.

Configuration
REQ-028 SHALL use macro HAZARD_SCOREBOARD_BYPASS_EN; when it is defined, a RAW hazard on register X is suppressed when X's counter is 1 and hs_i_wb_en is high with hs_i_wb_addr equal to X in the same cycle.
REQ-029 SHALL, when HAZARD_SCOREBOARD_BYPASS_EN is undefined, stall in that case and issue one cycle later.

Verification
REQ-030 SHALL test: issue a write to r5, then a reader of rs=r5 with no writeback -> hs_o_stall=1 continuously; wb r5 -> issue the next cycle (bypass off) or the same cycle (bypass on).
REQ-031 SHALL test: three issues writing r7 with no writeback, then a fourth r7 writer -> hs_o_stall=1 until one r7 writeback arrives.
REQ-032 SHALL test: issue a branch with BR_WAIT=2 and hs_i_ce held high -> hs_o_issue=0 for 2 cycles, then 1.
REQ-033 SHALL test: issue a write to r0 and read r0 -> no stall; hs_o_busy remains 0.
REQ-034 SHALL test: same-cycle issue of a write to r3 and wb r3 with counter 1 -> counter stays 1 and hs_o_busy stays 1.
REQ-035 SHALL test: assert hs_rst low during STALL with r9 pending -> all outputs 0 immediately; after release a reader of r9 issues without stall.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Issue-stage register scoreboard: 2-bit pending-write counters, RAW/WAW stall and post-branch issue block.
// Optional macro HAZARD_SCOREBOARD_BYPASS_EN lets a reader issue alongside the final writeback of its source.
module hazard_scoreboard #(
    parameter int AWIDTH  = 5,
    parameter int BR_WAIT = 2
) (
    input  logic              hs_clk,
    input  logic              hs_rst,
    input  logic              hs_i_ce,
    input  logic [AWIDTH-1:0] hs_i_addr_rs,
    input  logic [AWIDTH-1:0] hs_i_addr_rt,
    input  logic              hs_i_use_rs,
    input  logic              hs_i_use_rt,
    input  logic              hs_i_reg_wr,
    input  logic [AWIDTH-1:0] hs_i_addr_wr,
    input  logic              hs_i_branch,
    input  logic              hs_i_wb_en,
    input  logic [AWIDTH-1:0] hs_i_wb_addr,
    output logic              hs_o_issue,
    output logic              hs_o_stall,
    output logic              hs_o_busy
);
    localparam int NREG = 1 << AWIDTH;

    typedef enum logic [1:0] {S_RUN, S_STALL, S_BRW} state_t;

    state_t     state_q;
    logic [2:0] br_cnt_q;
    logic [1:0] cnt_q [NREG];
    logic [1:0] cnt_d [NREG];
    logic       busy_q;
    logic       any_pending;

    logic [1:0] cnt_rs, cnt_rt, cnt_wr, cnt_wb;
    logic       byp_rs, byp_rt;
    logic       raw_rs, raw_rt, waw, hazard;
    logic       issue_ok, inc_en, dec_en;

    assign cnt_rs = cnt_q[hs_i_addr_rs];
    assign cnt_rt = cnt_q[hs_i_addr_rt];
    assign cnt_wr = cnt_q[hs_i_addr_wr];
    assign cnt_wb = cnt_q[hs_i_wb_addr];

`ifdef HAZARD_SCOREBOARD_BYPASS_EN
    // The last outstanding write retiring this cycle satisfies the reader.
    assign byp_rs = (cnt_rs == 2'd1) && hs_i_wb_en && (hs_i_wb_addr == hs_i_addr_rs);
    assign byp_rt = (cnt_rt == 2'd1) && hs_i_wb_en && (hs_i_wb_addr == hs_i_addr_rt);
`else
    assign byp_rs = 1'b0;
    assign byp_rt = 1'b0;
`endif

    assign raw_rs = hs_i_use_rs && (hs_i_addr_rs != '0) && (cnt_rs != 2'd0) && !byp_rs;
    assign raw_rt = hs_i_use_rt && (hs_i_addr_rt != '0) && (cnt_rt != 2'd0) && !byp_rt;
    assign waw    = hs_i_reg_wr && (hs_i_addr_wr != '0) && (cnt_wr == 2'd3);
    assign hazard = raw_rs || raw_rt || waw;

    assign issue_ok   = hs_rst && hs_i_ce && !hazard && (state_q != S_BRW);
    assign hs_o_issue = issue_ok;
    assign hs_o_stall = hs_rst && hs_i_ce && !issue_ok;
    assign hs_o_busy  = busy_q;

    assign inc_en = issue_ok && hs_i_reg_wr && (hs_i_addr_wr != '0);
    assign dec_en = hs_i_wb_en && (hs_i_wb_addr != '0) && (cnt_wb != 2'd0);

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_cnt
            if (gi == 0) begin : g_zero
                assign cnt_d[gi] = 2'd0;
            end else begin : g_reg
                logic inc_hit, dec_hit;
                assign inc_hit = inc_en && (hs_i_addr_wr == AWIDTH'(gi));
                assign dec_hit = dec_en && (hs_i_wb_addr == AWIDTH'(gi));
                always_comb begin
                    cnt_d[gi] = cnt_q[gi];
                    if (inc_hit && !dec_hit)
                        cnt_d[gi] = cnt_q[gi] + 2'd1;
                    else if (dec_hit && !inc_hit)
                        cnt_d[gi] = cnt_q[gi] - 2'd1;
                end
            end
        end
    endgenerate

    always_comb begin
        any_pending = 1'b0;
        for (int i = 1; i < NREG; i++)
            any_pending = any_pending | (cnt_q[i] != 2'd0);
    end

    always_ff @(posedge hs_clk or negedge hs_rst) begin
        if (!hs_rst) begin
            for (int i = 0; i < NREG; i++)
                cnt_q[i] <= 2'd0;
            busy_q <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++)
                cnt_q[i] <= cnt_d[i];
            busy_q <= any_pending;
        end
    end

    // BR_WAIT counts the blocked cycles still to come; leaving at 1 gives exactly BR_WAIT of them.
    always_ff @(posedge hs_clk or negedge hs_rst) begin
        if (!hs_rst) begin
            state_q  <= S_RUN;
            br_cnt_q <= 3'd0;
        end else begin
            case (state_q)
                S_RUN, S_STALL: begin
                    if (issue_ok && hs_i_branch) begin
                        state_q  <= S_BRW;
                        br_cnt_q <= 3'(BR_WAIT);
                    end else if (hs_i_ce && !issue_ok) begin
                        state_q <= S_STALL;
                    end else begin
                        state_q <= S_RUN;
                    end
                end
                S_BRW: begin
                    if (br_cnt_q <= 3'd1) begin
                        state_q  <= S_RUN;
                        br_cnt_q <= 3'd0;
                    end else begin
                        br_cnt_q <= br_cnt_q - 3'd1;
                    end
                end
                default: begin
                    state_q  <= S_RUN;
                    br_cnt_q <= 3'd0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: each directed cycle pushes its expected {issue,stall,busy}; a monitor pops and checks.
module tb_hazard_scoreboard;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ce = 1'b0, use_rs = 1'b0, use_rt = 1'b0, reg_wr = 1'b0, branch = 1'b0, wb_en = 1'b0;
    logic [4:0] addr_rs = '0, addr_rt = '0, addr_wr = '0, wb_addr = '0;
    logic       issue, stall, busy;

    typedef struct {
        string      name;
        logic [2:0] exp;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    bit   stim_done = 1'b0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.AWIDTH(5), .BR_WAIT(2)) dut (
        .hs_clk      (clk),
        .hs_rst      (rst),
        .hs_i_ce     (ce),
        .hs_i_addr_rs(addr_rs),
        .hs_i_addr_rt(addr_rt),
        .hs_i_use_rs (use_rs),
        .hs_i_use_rt (use_rt),
        .hs_i_reg_wr (reg_wr),
        .hs_i_addr_wr(addr_wr),
        .hs_i_branch (branch),
        .hs_i_wb_en  (wb_en),
        .hs_i_wb_addr(wb_addr),
        .hs_o_issue  (issue),
        .hs_o_stall  (stall),
        .hs_o_busy   (busy)
    );

    // One clock cycle of stimulus; the expected outputs for that cycle go to the scoreboard.
    task automatic cyc(input string nm, input logic r, input logic c,
                       input logic urs, input logic [4:0] rs, input logic urt, input logic [4:0] rt,
                       input logic rw, input logic [4:0] wa, input logic br,
                       input logic wbe, input logic [4:0] wba,
                       input logic ei, input logic es, input logic eb);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; ce = c; use_rs = urs; addr_rs = rs; use_rt = urt; addr_rt = rt;
        reg_wr = rw; addr_wr = wa; branch = br; wb_en = wbe; wb_addr = wba;
        e.name = nm;
        e.exp  = {ei, es, eb};
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests++;
                if ({issue, stall, busy} !== e.exp) begin
                    fails++;
                    $display("FAIL %s: got issue/stall/busy=%b, expected %b", e.name, {issue, stall, busy}, e.exp);
                end else begin
                    $display("[TB] ok %s issue/stall/busy=%b", e.name, {issue, stall, busy});
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        //        name          rst ce  urs rs  urt rt  rw wa  br wbe wba  iss stl bsy
        cyc("reset_hold",   0, 1,  1, 5'd1, 0, 5'd0, 1, 5'd2, 0, 0, 5'd0,  0, 0, 0);
        cyc("reset_rel",    1, 0,  0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0,  0, 0, 0);
        // r0 never tracked
        cyc("r0_wr_rd",     1, 1,  1, 5'd0, 0, 5'd0, 1, 5'd0, 0, 0, 5'd0,  1, 0, 0);
        cyc("r0_rd_rt",     1, 1,  0, 5'd0, 1, 5'd0, 0, 5'd0, 0, 0, 5'd0,  1, 0, 0);
        cyc("r0_busy",      1, 0,  0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0,  0, 0, 0);
        // RAW on r5
        cyc("wr_r5",        1, 1,  0, 5'd0, 0, 5'd0, 1, 5'd5, 0, 0, 5'd0,  1, 0, 0);
        cyc("raw_r5_a",     1, 1,  1, 5'd5, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0,  0, 1, 0);
        cyc("raw_r5_b",     1, 1,  1, 5'd5, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0,  0, 1, 1);
        cyc("raw_r5_c",     1, 1,  1, 5'd5, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0,  0, 1, 1);
`ifdef HAZARD_SCOREBOARD_BYPASS_EN
        cyc("raw_r5_wb",    1, 1,  1, 5'd5, 0, 5'd0, 0, 5'd0, 0, 1, 5'd5,  1, 0, 1);
`else
        cyc("raw_r5_wb",    1, 1,  1, 5'd5, 0, 5'd0, 0, 5'd0, 0, 1, 5'd5,  0, 1, 1);
`endif
        cyc("raw_r5_go",    1, 1,  1, 5'd5, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0,  1, 0, 1);
        cyc("r5_idle",      1, 0,  0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0,  0, 0, 0);
        // WAW saturation on r7
        cyc("wr_r7_1",      1, 1,  0, 5'd0, 0, 5'd0, 1, 5'd7, 0, 0, 5'd0,  1, 0, 0);
        cyc("wr_r7_2",      1, 1,  0, 5'd0, 0, 5'd0, 1, 5'd7, 0, 0, 5'd0,  1, 0, 0);
        cyc("wr_r7_3",      1, 1,  0, 5'd0, 0, 5'd0, 1, 5'd7, 0, 0, 5'd0,  1, 0, 1);
        cyc("waw_r7_a",     1, 1,  0, 5'd0, 0, 5'd0, 1, 5'd7, 0, 0, 5'd0,  0, 1, 1);
        cyc("waw_r7_b",     1, 1,  0, 5'd0, 0, 5'd0, 1, 5'd7, 0, 0, 5'd0,  0, 1, 1);
        cyc("waw_r7_wb",    1, 1,  0, 5'd0, 0, 5'd0, 1, 5'd7, 0, 1, 5'd7,  0, 1, 1);
        cyc("waw_r7_go",    1, 1,  0, 5'd0, 0, 5'd0, 1, 5'd7, 0, 0, 5'd0,  1, 0, 1);
        cyc("drain_r7_1",   1, 0,  0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 5'd7,  0, 0, 1);
        cyc("drain_r7_2",   1, 0,  0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 5'd7,  0, 0, 1);
        cyc("drain_r7_3",   1, 0,  0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 5'd7,  0, 0, 1);
        cyc("drain_r7_4",   1, 0,  0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0,  0, 0, 1);
        cyc("drained_r7",   1, 0,  0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0,  0, 0, 0);
        // a writeback to an empty counter must not wrap it
        cyc("wb_zero",      1, 0,  0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 5'd7,  0, 0, 0);
        cyc("wb_zero_chk",  1, 0,  0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0,  0, 0, 0);
        // branch block, BR_WAIT=2
        cyc("branch",       1, 1,  0, 5'd0, 0, 5'd0, 0, 5'd0, 1, 0, 5'd0,  1, 0, 0);
        cyc("br_wait_1",    1, 1,  0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0,  0, 1, 0);
        cyc("br_wait_2",    1, 1,  0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0,  0, 1, 0);
        cyc("br_release",   1, 1,  0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0,  1, 0, 0);
        // writeback still retires while issue is blocked by a branch
        cyc("br_wr_r4",     1, 1,  0, 5'd0, 0, 5'd0, 1, 5'd4, 1, 0, 5'd0,  1, 0, 0);
        cyc("br_wb_r4",     1, 1,  0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 5'd4,  0, 1, 0);
        cyc("br_rd_r4",     1, 1,  1, 5'd4, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0,  0, 1, 1);
        cyc("rd_r4_go",     1, 1,  1, 5'd4, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0,  1, 0, 0);
        // same-cycle increment and decrement on r3
        cyc("wr_r3",        1, 1,  0, 5'd0, 0, 5'd0, 1, 5'd3, 0, 0, 5'd0,  1, 0, 0);
        cyc("wr_wb_r3",     1, 1,  0, 5'd0, 0, 5'd0, 1, 5'd3, 0, 1, 5'd3,  1, 0, 0);
        cyc("r3_busy_a",    1, 0,  0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0,  0, 0, 1);
        cyc("r3_busy_b",    1, 0,  0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0,  0, 0, 1);
        cyc("r3_wb",        1, 0,  0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 5'd3,  0, 0, 1);
        cyc("r3_busy_c",    1, 0,  0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0,  0, 0, 1);
        cyc("r3_clear",     1, 0,  0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0,  0, 0, 0);
        // rt source and the use flags
        cyc("wr_r12",       1, 1,  0, 5'd0, 0, 5'd0, 1, 5'd12, 0, 0, 5'd0, 1, 0, 0);
        cyc("r12_unused",   1, 1,  0, 5'd12, 0, 5'd12, 0, 5'd0, 0, 0, 5'd0, 1, 0, 0);
        cyc("raw_rt_r12",   1, 1,  0, 5'd0, 1, 5'd12, 0, 5'd0, 0, 0, 5'd0, 0, 1, 1);
        cyc("wb_r12",       1, 0,  0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 1, 5'd12, 0, 0, 1);
        cyc("r12_busy",     1, 0,  0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0,  0, 0, 1);
        cyc("r12_clear",    1, 0,  0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0,  0, 0, 0);
        // reset in the middle of a stall on r9
        cyc("wr_r9",        1, 1,  0, 5'd0, 0, 5'd0, 1, 5'd9, 0, 0, 5'd0,  1, 0, 0);
        cyc("raw_r9_a",     1, 1,  1, 5'd9, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0,  0, 1, 0);
        cyc("raw_r9_b",     1, 1,  1, 5'd9, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0,  0, 1, 1);
        cyc("rst_stall_a",  0, 1,  1, 5'd9, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0,  0, 0, 0);
        cyc("rst_stall_b",  0, 1,  1, 5'd9, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0,  0, 0, 0);
        cyc("post_rst_r9",  1, 1,  1, 5'd9, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0,  1, 0, 0);
        cyc("post_rst_idle",1, 0,  0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 5'd0,  0, 0, 0);
        stim_done = 1'b1;
        repeat (3) @(posedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
